// File: rtl/hazard_forward_unit_if.sv
// Datapath <-> hazard/forward controller bundle: pipeline register fields in,
// forwarding selects, stall/flush controls and MDU scoreboard status out.
interface hazard_forward_unit_if #(
  parameter int AW = 5,
  parameter int CW = 16
);
  logic [AW-1:0] rs_id, rt_id, dst_id;
  logic          regwrite_id, mdu_op_id, branch_id;
  logic [AW-1:0] rs_ex, rt_ex, dst_ex;
  logic          regwrite_ex, memtoreg_ex, mdu_start_ex;
  logic [AW-1:0] dst_m;
  logic          regwrite_m, memtoreg_m;
  logic [AW-1:0] dst_wb;
  logic          regwrite_wb;

  logic [1:0]    forward_ae, forward_be;
  logic          forward_ad, forward_bd;
  logic          stall_f, stall_d, flush_e;
  logic          mdu_busy, mdu_wb_valid;
  logic [AW-1:0] mdu_dst;
  logic [CW-1:0] stall_count;

  modport master (
    output rs_id, rt_id, dst_id, regwrite_id, mdu_op_id, branch_id,
           rs_ex, rt_ex, dst_ex, regwrite_ex, memtoreg_ex, mdu_start_ex,
           dst_m, regwrite_m, memtoreg_m, dst_wb, regwrite_wb,
    input  forward_ae, forward_be, forward_ad, forward_bd,
           stall_f, stall_d, flush_e, mdu_busy, mdu_wb_valid, mdu_dst, stall_count
  );

  modport slave (
    input  rs_id, rt_id, dst_id, regwrite_id, mdu_op_id, branch_id,
           rs_ex, rt_ex, dst_ex, regwrite_ex, memtoreg_ex, mdu_start_ex,
           dst_m, regwrite_m, memtoreg_m, dst_wb, regwrite_wb,
    output forward_ae, forward_be, forward_ad, forward_bd,
           stall_f, stall_d, flush_e, mdu_busy, mdu_wb_valid, mdu_dst, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the MIPS pipeline, with a
// single-entry scoreboard for the fixed-latency multiply/divide unit.
module hazard_forward_unit #(
  parameter int AW          = 5,
  parameter int MDU_LAT     = 4,
  parameter int CW          = 16,
  parameter int ZERO_REG_EN = 1
) (
  input  logic clk,
  input  logic reset,
  hazard_forward_unit_if.slave hif
);
  localparam int CNTW = $clog2(MDU_LAT + 1);

  typedef enum logic {IDLE, BUSY} sb_state_e;

  sb_state_e       state;
  logic [CNTW-1:0] cnt;
  logic [AW-1:0]   mdu_dst_q;
  logic [CW-1:0]   stall_cnt_q;

  logic mdu_busy, mdu_wb_valid;
  logic lw_stall, br_stall, mdu_stall, stall;

  function automatic logic match(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && !((ZERO_REG_EN != 0) && (a == '0));
  endfunction

  assign mdu_busy     = (state == BUSY);
  assign mdu_wb_valid = mdu_busy && (cnt == CNTW'(1));

  // index 0 = rs operand, index 1 = rt operand
  logic [1:0][AW-1:0] src_ex, src_id;
  logic [1:0][1:0]    fwd_e;
  logic [1:0]         fwd_d, hit_ex, hit_m, hit_mdu;

  assign src_ex = {hif.rt_ex, hif.rs_ex};
  assign src_id = {hif.rt_id, hif.rs_id};

  for (genvar i = 0; i < 2; i++) begin : g_opnd
    assign fwd_e[i]   = (hif.regwrite_m  && match(hif.dst_m,  src_ex[i])) ? 2'b10 :
                        (hif.regwrite_wb && match(hif.dst_wb, src_ex[i])) ? 2'b01 :
                        (mdu_wb_valid    && match(mdu_dst_q,  src_ex[i])) ? 2'b11 : 2'b00;
    assign fwd_d[i]   = hif.regwrite_m && !hif.memtoreg_m && match(hif.dst_m, src_id[i]);
    assign hit_ex[i]  = match(hif.dst_ex, src_id[i]);
    assign hit_m[i]   = match(hif.dst_m,  src_id[i]);
    assign hit_mdu[i] = match(mdu_dst_q,  src_id[i]);
  end

  assign lw_stall = hif.memtoreg_ex && hif.regwrite_ex && (|hit_ex);
  assign br_stall = hif.branch_id &&
                    ((hif.regwrite_ex && (|hit_ex)) || (hif.memtoreg_m && (|hit_m)));

  // RAW on the outstanding/issuing op, WAW against it, and a second MDU op
  // may only enter EX in the write-back cycle of the current one.
  assign mdu_stall = (mdu_busy && (|hit_mdu)) ||
                     (hif.mdu_start_ex && (|hit_ex)) ||
                     (hif.regwrite_id &&
                       ((mdu_busy && match(mdu_dst_q, hif.dst_id)) ||
                        (hif.mdu_start_ex && match(hif.dst_ex, hif.dst_id)))) ||
                     (hif.mdu_op_id && ((mdu_busy && !mdu_wb_valid) || hif.mdu_start_ex));

  assign stall = lw_stall | br_stall | mdu_stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      mdu_dst_q <= '0;
    end else begin
      case (state)
        IDLE: if (hif.mdu_start_ex) begin
          state     <= BUSY;
          cnt       <= CNTW'(MDU_LAT - 1);
          mdu_dst_q <= hif.dst_ex;
        end
        BUSY: if (mdu_wb_valid) begin
          if (hif.mdu_start_ex) begin
            cnt       <= CNTW'(MDU_LAT - 1);
            mdu_dst_q <= hif.dst_ex;
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end else begin
          cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     stall_cnt_q <= '0;
    else if (stall && ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign hif.forward_ae   = fwd_e[0];
  assign hif.forward_be   = fwd_e[1];
  assign hif.forward_ad   = fwd_d[0];
  assign hif.forward_bd   = fwd_d[1];
  assign hif.stall_f      = stall;
  assign hif.stall_d      = stall;
  assign hif.flush_e      = stall;
  assign hif.mdu_busy     = mdu_busy;
  assign hif.mdu_wb_valid = mdu_wb_valid;
  assign hif.mdu_dst      = mdu_dst_q;
  assign hif.stall_count  = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed and randomized checks of hazard_forward_unit against an
// issue-time-based reference model of the MDU scoreboard and hazard rules.
module tb_hazard_forward_unit;
  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.AW(AW), .CW(CW)) bus ();

  hazard_forward_unit #(.AW(AW), .MDU_LAT(LAT), .CW(CW), .ZERO_REG_EN(1)) dut (
    .clk(clk), .reset(reset), .hif(bus)
  );

  int checks = 0;
  int errors = 0;

  // model: edge counter, edge index of the outstanding issue (-1 = none)
  int            edges = 0;
  int            issue_edge = -1;
  logic [AW-1:0] m_dst = '0;
  int            m_cnt = 0;

  logic [1:0]    e_fae, e_fbe;
  logic          e_fad, e_fbd, e_stall, e_busy, e_wbv;

  function automatic logic mt(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return (a == b) && (a != 0);
  endfunction

  function automatic logic [1:0] fsel(input logic [AW-1:0] src, input logic wbv);
    if (bus.regwrite_m && mt(bus.dst_m, src))   return 2'b10;
    if (bus.regwrite_wb && mt(bus.dst_wb, src)) return 2'b01;
    if (wbv && mt(m_dst, src))                  return 2'b11;
    return 2'b00;
  endfunction

  task automatic model_eval();
    logic lw, br, md, hex, hm;
    e_busy = !reset && issue_edge >= 0 && edges < issue_edge + LAT - 1;
    e_wbv  = e_busy && edges == issue_edge + LAT - 2;
    e_fae  = fsel(bus.rs_ex, e_wbv);
    e_fbe  = fsel(bus.rt_ex, e_wbv);
    e_fad  = bus.regwrite_m && !bus.memtoreg_m && mt(bus.dst_m, bus.rs_id);
    e_fbd  = bus.regwrite_m && !bus.memtoreg_m && mt(bus.dst_m, bus.rt_id);
    hex = mt(bus.dst_ex, bus.rs_id) || mt(bus.dst_ex, bus.rt_id);
    hm  = mt(bus.dst_m, bus.rs_id) || mt(bus.dst_m, bus.rt_id);
    lw  = bus.memtoreg_ex && bus.regwrite_ex && hex;
    br  = bus.branch_id && ((bus.regwrite_ex && hex) || (bus.memtoreg_m && hm));
    md  = (e_busy && (mt(m_dst, bus.rs_id) || mt(m_dst, bus.rt_id))) ||
          (bus.mdu_start_ex && hex) ||
          (bus.regwrite_id && ((e_busy && mt(m_dst, bus.dst_id)) ||
                               (bus.mdu_start_ex && mt(bus.dst_ex, bus.dst_id)))) ||
          (bus.mdu_op_id && ((e_busy && !e_wbv) || bus.mdu_start_ex));
    e_stall = lw | br | md;
  endtask

  task automatic tick();
    logic acc;
    logic [AW-1:0] d;
    model_eval();
    acc = bus.mdu_start_ex && (!e_busy || e_wbv);
    d   = bus.dst_ex;
    @(posedge clk);
    edges++;
    if (reset) begin
      issue_edge = -1; m_dst = '0; m_cnt = 0;
    end else begin
      if (e_stall && m_cnt < SAT) m_cnt++;
      if (acc) begin issue_edge = edges; m_dst = d; end
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.rs_id = '0; bus.rt_id = '0; bus.dst_id = '0;
    bus.regwrite_id = 0; bus.mdu_op_id = 0; bus.branch_id = 0;
    bus.rs_ex = '0; bus.rt_ex = '0; bus.dst_ex = '0;
    bus.regwrite_ex = 0; bus.memtoreg_ex = 0; bus.mdu_start_ex = 0;
    bus.dst_m = '0; bus.regwrite_m = 0; bus.memtoreg_m = 0;
    bus.dst_wb = '0; bus.regwrite_wb = 0;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (LAT + 1) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    #2;
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.mdu_busy); end
    checks++; if (bus.mdu_wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wbv got %b want 0", bus.mdu_wb_valid); end
    checks++; if (bus.stall_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.stall_count); end
    checks++; if (bus.mdu_dst !== '0) begin errors++; $display("FAIL reset_dst got %0d want 0", bus.mdu_dst); end
    checks++; if ({bus.forward_ae, bus.forward_be, bus.stall_f} !== 5'b0) begin errors++;
      $display("FAIL reset_comb got %b want 00000", {bus.forward_ae, bus.forward_be, bus.stall_f}); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ex_forward();
    clear_inputs();
    bus.regwrite_m = 1; bus.dst_m = 8; bus.regwrite_wb = 1; bus.dst_wb = 8;
    bus.rs_ex = 8; bus.rt_ex = 8;
    #1;
    checks++; if (bus.forward_ae !== 2'b10) begin errors++; $display("FAIL fwd_m_over_wb got %b want 10", bus.forward_ae); end
    checks++; if (bus.forward_be !== 2'b10) begin errors++; $display("FAIL fwd_be_m got %b want 10", bus.forward_be); end
    bus.regwrite_m = 0;
    #1;
    checks++; if (bus.forward_ae !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b want 01", bus.forward_ae); end
    bus.regwrite_m = 1; bus.dst_m = 0; bus.dst_wb = 0; bus.rs_ex = 0;
    #1;
    checks++; if (bus.forward_ae !== 2'b00) begin errors++; $display("FAIL fwd_zero_reg got %b want 00", bus.forward_ae); end
    tick();
  endtask

  task automatic test_load_use();
    int exp_cnt;
    clear_inputs();
    bus.memtoreg_ex = 1; bus.regwrite_ex = 1; bus.dst_ex = 9; bus.rt_id = 9;
    #1;
    checks++; if ({bus.stall_f, bus.stall_d, bus.flush_e} !== 3'b111) begin errors++;
      $display("FAIL load_use_stall got %b want 111", {bus.stall_f, bus.stall_d, bus.flush_e}); end
    exp_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
    tick();
    checks++; if (bus.stall_count !== CW'(exp_cnt)) begin errors++;
      $display("FAIL load_use_count got %0d want %0d", bus.stall_count, exp_cnt); end
    bus.memtoreg_ex = 0;
    #1;
    checks++; if (bus.stall_d !== 1'b0) begin errors++; $display("FAIL load_use_clear got %b want 0", bus.stall_d); end
    tick();
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.branch_id = 1; bus.rs_id = 4; bus.regwrite_ex = 1; bus.dst_ex = 4;
    #1;
    checks++; if (bus.stall_d !== 1'b1) begin errors++; $display("FAIL br_ex got %b want 1", bus.stall_d); end
    bus.regwrite_ex = 0; bus.memtoreg_m = 1; bus.dst_m = 4;
    #1;
    checks++; if (bus.stall_d !== 1'b1) begin errors++; $display("FAIL br_load_m got %b want 1", bus.stall_d); end
    bus.memtoreg_m = 0; bus.regwrite_m = 1; bus.rt_id = 4;
    #1;
    checks++; if (bus.stall_f !== 1'b0) begin errors++; $display("FAIL br_alu_m_stall got %b want 0", bus.stall_f); end
    checks++; if ({bus.forward_ad, bus.forward_bd} !== 2'b11) begin errors++;
      $display("FAIL br_fwd_d got %b want 11", {bus.forward_ad, bus.forward_bd}); end
    tick();
  endtask

  task automatic test_mdu_timing();
    drain();
    bus.mdu_start_ex = 1; bus.dst_ex = 12;
    #1;
    checks++; if (bus.mdu_busy !== 1'b0) begin errors++; $display("FAIL mdu_pre_busy got %b want 0", bus.mdu_busy); end
    tick();
    bus.mdu_start_ex = 0; bus.dst_ex = 0;
    for (int k = 0; k < 4; k++) begin
      bus.rs_id = 12; bus.rs_ex = 12;
      #1;
      checks++; if (bus.mdu_busy !== (k < 3)) begin errors++; $display("FAIL mdu_busy_%0d got %b want %b", k, bus.mdu_busy, k < 3); end
      checks++; if (bus.mdu_wb_valid !== (k == 2)) begin errors++; $display("FAIL mdu_wbv_%0d got %b want %b", k, bus.mdu_wb_valid, k == 2); end
      checks++; if (bus.stall_d !== (k < 3)) begin errors++; $display("FAIL mdu_raw_%0d got %b want %b", k, bus.stall_d, k < 3); end
      checks++; if (bus.forward_ae !== ((k == 2) ? 2'b11 : 2'b00)) begin errors++;
        $display("FAIL mdu_fwd_%0d got %b want %b", k, bus.forward_ae, (k == 2) ? 2'b11 : 2'b00); end
      if (k < 3) begin
        checks++; if (bus.mdu_dst !== 5'd12) begin errors++; $display("FAIL mdu_dst_%0d got %0d want 12", k, bus.mdu_dst); end
      end
      tick();
    end
  endtask

  task automatic test_mdu_struct();
    drain();
    bus.mdu_start_ex = 1; bus.dst_ex = 12;
    tick();
    bus.mdu_start_ex = 0; bus.dst_ex = 0;
    bus.mdu_op_id = 1;
    #1;
    checks++; if (bus.stall_d !== 1'b1) begin errors++; $display("FAIL mdu_struct got %b want 1", bus.stall_d); end
    bus.mdu_op_id = 0; bus.regwrite_id = 1; bus.dst_id = 12;
    #1;
    checks++; if (bus.stall_d !== 1'b1) begin errors++; $display("FAIL mdu_waw got %b want 1", bus.stall_d); end
    bus.dst_id = 5;
    #1;
    checks++; if (bus.stall_d !== 1'b0) begin errors++; $display("FAIL mdu_no_waw got %b want 0", bus.stall_d); end
    bus.regwrite_id = 0;
    tick(); tick();
    bus.mdu_op_id = 1;
    #1;
    checks++; if ({bus.mdu_wb_valid, bus.stall_d} !== 2'b10) begin errors++;
      $display("FAIL mdu_final_op got %b want 10", {bus.mdu_wb_valid, bus.stall_d}); end
    bus.mdu_op_id = 0; bus.mdu_start_ex = 1; bus.dst_ex = 13;
    tick();
    bus.mdu_start_ex = 0; bus.dst_ex = 0;
    #1;
    checks++; if ({bus.mdu_busy, bus.mdu_wb_valid} !== 2'b10) begin errors++;
      $display("FAIL b2b_busy got %b want 10", {bus.mdu_busy, bus.mdu_wb_valid}); end
    checks++; if (bus.mdu_dst !== 5'd13) begin errors++; $display("FAIL b2b_dst got %0d want 13", bus.mdu_dst); end
    tick(); tick();
    checks++; if (bus.mdu_wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wbv got %b want 1", bus.mdu_wb_valid); end
    tick();
  endtask

  task automatic test_saturation();
    clear_inputs();
    bus.memtoreg_ex = 1; bus.regwrite_ex = 1; bus.dst_ex = 3; bus.rs_id = 3;
    repeat (SAT + 5) tick();
    checks++; if (bus.stall_count !== CW'(SAT)) begin errors++; $display("FAIL sat_count got %0d want %0d", bus.stall_count, SAT); end
    tick();
    checks++; if (bus.stall_count !== CW'(SAT)) begin errors++; $display("FAIL sat_hold got %0d want %0d", bus.stall_count, SAT); end
  endtask

  task automatic test_reset_midop();
    drain();
    bus.mdu_start_ex = 1; bus.dst_ex = 7;
    tick();
    bus.mdu_start_ex = 0; bus.dst_ex = 0;
    tick();
    #2 reset = 1'b1;
    issue_edge = -1; m_dst = '0; m_cnt = 0;
    #1;
    checks++; if ({bus.mdu_busy, bus.mdu_wb_valid} !== 2'b00) begin errors++;
      $display("FAIL rst_mid_mdu got %b want 00", {bus.mdu_busy, bus.mdu_wb_valid}); end
    checks++; if (bus.stall_count !== '0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", bus.stall_count); end
    #2 reset = 1'b0;
    bus.mdu_start_ex = 1; bus.dst_ex = 20;
    tick();
    bus.mdu_start_ex = 0; bus.dst_ex = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({bus.mdu_busy, bus.mdu_wb_valid} !== {k < 3, k == 2}) begin errors++;
        $display("FAIL rst_reissue_%0d got %b want %b", k, {bus.mdu_busy, bus.mdu_wb_valid}, {k < 3, k == 2}); end
      if (k == 0) begin
        checks++; if (bus.mdu_dst !== 5'd20) begin errors++; $display("FAIL rst_reissue_dst got %0d want 20", bus.mdu_dst); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      bus.rs_id = AW'($urandom_range(0, 3)); bus.rt_id = AW'($urandom_range(0, 3));
      bus.dst_id = AW'($urandom_range(0, 3));
      bus.regwrite_id = 1'($urandom); bus.mdu_op_id = 1'($urandom); bus.branch_id = 1'($urandom);
      bus.rs_ex = AW'($urandom_range(0, 3)); bus.rt_ex = AW'($urandom_range(0, 3));
      bus.dst_ex = AW'($urandom_range(0, 3));
      bus.regwrite_ex = 1'($urandom); bus.memtoreg_ex = ($urandom_range(0, 3) == 0);
      bus.mdu_start_ex = ($urandom_range(0, 2) == 0);
      bus.dst_m = AW'($urandom_range(0, 3)); bus.regwrite_m = 1'($urandom); bus.memtoreg_m = 1'($urandom);
      bus.dst_wb = AW'($urandom_range(0, 3)); bus.regwrite_wb = 1'($urandom);
      #1;
      model_eval();
      checks++; if (bus.forward_ae !== e_fae) begin errors++; $display("FAIL rnd_fae n=%0d got %b want %b", n, bus.forward_ae, e_fae); end
      checks++; if (bus.forward_be !== e_fbe) begin errors++; $display("FAIL rnd_fbe n=%0d got %b want %b", n, bus.forward_be, e_fbe); end
      checks++; if ({bus.forward_ad, bus.forward_bd} !== {e_fad, e_fbd}) begin errors++;
        $display("FAIL rnd_fwd_d n=%0d got %b want %b", n, {bus.forward_ad, bus.forward_bd}, {e_fad, e_fbd}); end
      checks++; if ({bus.stall_f, bus.stall_d, bus.flush_e} !== {3{e_stall}}) begin errors++;
        $display("FAIL rnd_stall n=%0d got %b want %b", n, {bus.stall_f, bus.stall_d, bus.flush_e}, {3{e_stall}}); end
      checks++; if ({bus.mdu_busy, bus.mdu_wb_valid} !== {e_busy, e_wbv}) begin errors++;
        $display("FAIL rnd_mdu n=%0d got %b want %b", n, {bus.mdu_busy, bus.mdu_wb_valid}, {e_busy, e_wbv}); end
      checks++; if (bus.stall_count !== CW'(m_cnt)) begin errors++;
        $display("FAIL rnd_count n=%0d got %0d want %0d", n, bus.stall_count, m_cnt); end
      if (e_busy) begin
        checks++; if (bus.mdu_dst !== m_dst) begin errors++; $display("FAIL rnd_dst n=%0d got %0d want %0d", n, bus.mdu_dst, m_dst); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ex_forward();
    test_load_use();
    test_branch();
    test_mdu_timing();
    test_mdu_struct();
    test_random();
    test_saturation();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
